mem_compare_engine: RTL

Synthesisable memory checker that walks a window of a device memory and a gold memory in lock-step, compares masked words, and reports the mismatch count and first-failure details. It replaces the end-of-simulation software DFM-vs-gold loop for the pipelined MCU. It sits beside the DFM and a gold ROM on shared read-address lines, so the same check runs in simulation, emulation and FPGA bring-up. It adds window selection, bit masking and stop-on-first-error, none of which the loop had.

---
 rtl/mem_compare_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_compare_engine.sv
// rtl/mem_compare_engine.sv - lock-step masked compare of a device memory window against a gold memory
module mem_compare_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  stop_first,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [DATA_WIDTH-1:0] cmp_mask,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] dut_rd_data,
  input  logic [DATA_WIDTH-1:0] gold_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH:0]   words_checked,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_dut,
  output logic [DATA_WIDTH-1:0] first_err_gold
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state_q;
  logic                  rd_en_q, busy_q, done_q, pass_q, stop_q, fev_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, cmp_addr_q, faddr_q;
  logic [ADDR_WIDTH:0]   rem_q, err_q, words_q;
  logic [DATA_WIDTH-1:0] mask_q, fdut_q, fgold_q;
  logic                  cmp_pending_q;
  logic                  mismatch_d;
  logic [ADDR_WIDTH:0]   err_d;

  // Read data returns one cycle after the strobe, so the compare tracks the previous read.
  always_comb begin
    mismatch_d = cmp_pending_q && (((dut_rd_data ^ gold_rd_data) & mask_q) != '0);
    err_d      = mismatch_d ? err_q + CNT_ONE : err_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      cmp_addr_q    <= '0;
      cmp_pending_q <= 1'b0;
      rem_q         <= '0;
      mask_q        <= '0;
      stop_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      words_q       <= '0;
      fev_q         <= 1'b0;
      faddr_q       <= '0;
      fdut_q        <= '0;
      fgold_q       <= '0;
    end else begin
      if (cmp_pending_q) begin
        words_q <= words_q + CNT_ONE;
        err_q   <= err_d;
        if (mismatch_d && !fev_q) begin
          fev_q   <= 1'b1;
          faddr_q <= cmp_addr_q;
          fdut_q  <= dut_rd_data;
          fgold_q <= gold_rd_data;
        end
      end
      cmp_pending_q <= 1'b0;
      cmp_addr_q    <= rd_addr_q;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q  <= cmp_mask;
            stop_q  <= stop_first;
            busy_q  <= 1'b1;
            err_q   <= '0;
            words_q <= '0;
            fev_q   <= 1'b0;
            faddr_q <= '0;
            fdut_q  <= '0;
            fgold_q <= '0;
            if (word_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q   <= S_READ;
              pass_q    <= 1'b0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr;
              rem_q     <= word_count - CNT_ONE;
            end
          end
        end
        S_READ: begin
          cmp_pending_q <= 1'b1;
          if (stop_q && mismatch_d) begin
            // The read issued this cycle is abandoned: its compare never happens.
            cmp_pending_q <= 1'b0;
            rd_en_q       <= 1'b0;
            done_q        <= 1'b1;
            pass_q        <= 1'b0;
            state_q       <= S_DONE;
          end else if (rem_q == '0) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_ONE;
            rem_q     <= rem_q - CNT_ONE;
          end
        end
        S_DRAIN: begin
          done_q  <= 1'b1;
          pass_q  <= (err_d == '0);
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_rd_addr     = rd_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign words_checked   = words_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = faddr_q;
  assign first_err_dut   = fdut_q;
  assign first_err_gold  = fgold_q;

endmodule
